// File: rtl/crc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crc_arb_pkg
// Brief    : Shared widths and state encoding for the CRC-5 engine arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package crc_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int CRC_W   = 5;
    localparam int BYTE_W  = 8;

    localparam int c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_LOAD   = 3'd1;
    localparam state_t c_ST_FEED   = 3'd2;
    localparam state_t c_ST_WAIT   = 3'd3;
    localparam state_t c_ST_FINISH = 3'd4;
    localparam state_t c_ST_DONE   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Combinational two-way round-robin grant (one-hot output).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import crc_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_last,
    output logic [NUM_REQ-1:0] o_grant
);

    // i_last is the index served last; on contention the other one wins.
    always_comb begin
        o_grant = '0;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
            default: o_grant = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/crc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : crc_arbiter
// Brief    : Round-robin sequencer feeding two requesters' frames to the
//            shared CRC-5 engine. Optional FINISH timeout: CRC_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module crc_arbiter
    import crc_arb_pkg::*;
#(
    parameter int BYTE_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                      i_sys_clk,
    input  logic                      i_sys_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_last,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_crc_done,
    output logic [CRC_W-1:0]          o_crc_result,
    output logic                      o_busy,
    output logic [BYTE_W-1:0]         o_crc_data,
    output logic                      o_crc_input_valid,
    output logic                      o_crc_enable,
    output logic                      o_crc_end_byte,
    input  logic [CRC_W-1:0]          i_crc_value,
    input  logic                      i_crc_valid
`ifdef CRC_TIMEOUT_EN
    ,
    output logic                      o_crc_error
`endif
);

    localparam int c_CNT_W = $clog2(BYTE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(BYTE_CYCLES - 2);

    if (BYTE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("crc_arbiter: BYTE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  w_grant;
    logic                r_ptr;
    logic                r_last;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [BYTE_W-1:0]   r_crc_data;
    logic [CRC_W-1:0]    r_crc_result;
    logic                w_handshake;
    logic [BYTE_W-1:0]   w_sel_data;
    logic                w_sel_last;
    logic                w_tmo_hit;

    rr_arbiter2 u_rr (
        .i_req   (i_req_valid),
        .i_last  (r_ptr),
        .o_grant (w_grant)
    );

    assign w_sel_data  = r_grant[1] ? i_req_data[2*BYTE_W-1:BYTE_W] : i_req_data[BYTE_W-1:0];
    assign w_sel_last  = |(i_req_last & r_grant);
    assign w_handshake = (r_state == c_ST_LOAD) && |(i_req_valid & r_grant);

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            r_state      <= c_ST_IDLE;
            r_grant      <= '0;
            r_ptr        <= 1'b1;
            r_last       <= 1'b0;
            r_cnt        <= '0;
            r_crc_data   <= '0;
            r_crc_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_ST_IDLE: if (|i_req_valid) r_grant <= w_grant;
                c_ST_LOAD: begin
                    if (w_handshake) begin
                        r_crc_data <= w_sel_data;
                        r_last     <= w_sel_last;
                    end
                end
                c_ST_FEED: r_cnt <= c_CNT_LOAD;
                c_ST_WAIT: if (r_cnt != '0) r_cnt <= r_cnt - c_CNT_ONE;
                c_ST_FINISH: if (i_crc_valid) r_crc_result <= i_crc_value;
                c_ST_DONE: r_ptr <= r_grant[1];
                default: ;
            endcase
        end
    end

    // WAIT leaves as the count steps to zero so the byte pitch equals BYTE_CYCLES.
    always_comb begin
        w_state_nxt       = r_state;
        o_req_ready       = '0;
        o_crc_done        = '0;
        o_crc_input_valid = 1'b0;
        o_crc_end_byte    = 1'b0;
        case (r_state)
            c_ST_IDLE: if (|i_req_valid) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD: begin
                o_req_ready = r_grant;
                if (w_handshake) w_state_nxt = c_ST_FEED;
            end
            c_ST_FEED: begin
                o_crc_input_valid = 1'b1;
                w_state_nxt       = c_ST_WAIT;
            end
            c_ST_WAIT: if (r_cnt <= c_CNT_ONE) w_state_nxt = r_last ? c_ST_FINISH : c_ST_LOAD;
            c_ST_FINISH: begin
                o_crc_end_byte = 1'b1;
                if (i_crc_valid || w_tmo_hit) w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE: begin
                o_crc_done  = r_grant;
                w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign o_busy       = (r_state != c_ST_IDLE);
    assign o_crc_enable = (r_state != c_ST_IDLE);
    assign o_crc_data   = r_crc_data;
    assign o_crc_result = r_crc_result;

`ifdef CRC_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_tmo;
    logic               r_abort;

    // A late engine result in the final cycle still wins over the abort.
    assign w_tmo_hit   = (r_state == c_ST_FINISH) && !i_crc_valid && (r_tmo == c_TMO_LAST);
    assign o_crc_error = (r_state == c_ST_DONE) && r_abort;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            r_tmo   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_tmo   <= (r_state == c_ST_FINISH) ? r_tmo + 1'b1 : '0;
            r_abort <= w_tmo_hit;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_arbiter
// Brief    : Directed, table-driven bench for crc_arbiter with a CRC-5 engine model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_arbiter;
    import crc_arb_pkg::*;

    localparam int BC      = 8;
    localparam int TC      = 32;
    localparam int ENG_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  o_req_ready;
    logic [1:0]  o_crc_done;
    logic [4:0]  o_crc_result;
    logic        o_busy;
    logic [7:0]  o_crc_data;
    logic        o_crc_input_valid;
    logic        o_crc_enable;
    logic        o_crc_end_byte;
    logic [4:0]  crc_value;
    logic        crc_valid;
`ifdef CRC_TIMEOUT_EN
    logic        o_crc_error;
`endif

    crc_arbiter #(.BYTE_CYCLES(BC), .TIMEOUT_CYCLES(TC)) dut (
        .i_sys_clk         (clk),
        .i_sys_rst         (rst_n),
        .i_req_valid       (req_valid),
        .i_req_data        (req_data),
        .i_req_last        (req_last),
        .o_req_ready       (o_req_ready),
        .o_crc_done        (o_crc_done),
        .o_crc_result      (o_crc_result),
        .o_busy            (o_busy),
        .o_crc_data        (o_crc_data),
        .o_crc_input_valid (o_crc_input_valid),
        .o_crc_enable      (o_crc_enable),
        .o_crc_end_byte    (o_crc_end_byte),
        .i_crc_value       (crc_value),
        .i_crc_valid       (crc_valid)
`ifdef CRC_TIMEOUT_EN
        ,
        .o_crc_error       (o_crc_error)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CRC-5, x^5+x^2+1, seed 5'h1F, MSB first
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[4] ^ d[i];
            r  = {r[3:0], 1'b0};
            if (fb) r = r ^ 5'b00101;
        end
        return r;
    endfunction

    function automatic logic [4:0] crc5_frame(input logic [31:0] b, input int n);
        logic [4:0] r;
        r = 5'h1F;
        for (int k = 0; k < n; k++) r = crc5_byte(r, b[8*k +: 8]);
        return r;
    endfunction

    // Engine model: accumulates while enabled, answers ENG_LAT cycles into end_byte.
    logic [4:0] eng_crc;
    int         eng_cnt;
    logic       eng_mute;
    logic       eng_spur;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_crc <= 5'h1F;
            eng_cnt <= 0;
        end else begin
            if (!o_crc_enable)          eng_crc <= 5'h1F;
            else if (o_crc_input_valid) eng_crc <= crc5_byte(eng_crc, o_crc_data);
            eng_cnt <= o_crc_end_byte ? eng_cnt + 1 : 0;
        end
    end
    assign crc_valid = (o_crc_end_byte && (eng_cnt == ENG_LAT) && !eng_mute) || eng_spur;
    assign crc_value = eng_crc;

    int both_ready = 0;
    always @(negedge clk) if (o_req_ready == 2'b11) both_ready <= both_ready + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int who, input int n, input logic [31:0] bytes, input int stall,
                              input logic [1:0] exp_done, input logic [4:0] exp_crc);
        int         t_hs;
        int         t_end;
        int         w;
        logic [7:0] b;
        logic [1:0] me;
        me   = 2'b01 << who;
        t_hs = cyc;
        for (int k = 0; k < n; k++) begin
            b = bytes[8*k +: 8];
            if (k == 1 && stall > 0) begin
                req_valid[who] = 1'b0;
                repeat (stall) tick();
                check("stall_ready_held", 32'(o_req_ready), 32'(me));
                check("stall_busy", 32'(o_busy), 32'd1);
            end
            req_data[8*who +: 8] = b;
            req_last[who]        = (k == n - 1);
            req_valid[who]       = 1'b1;
            w = 0;
            while (o_req_ready == 2'b00 && w < 200) begin tick(); w++; end
            if (k == 0)                      check("grant", 32'(o_req_ready), 32'(me));
            else if (!(k == 1 && stall > 0)) check("byte_pitch", 32'(cyc - t_hs), 32'(BC));
            t_hs = cyc;
            tick();
            req_valid[who] = 1'b0;
            check("feed_strobe", 32'(o_crc_input_valid), 32'd1);
            check("feed_data", 32'(o_crc_data), 32'(b));
        end
        w = 0;
        while (!o_crc_end_byte && w < 200) begin tick(); w++; end
        check("end_byte_delay", 32'(cyc - t_hs), 32'(BC));
        t_end = cyc;
        w = 0;
        while (o_crc_done == 2'b00 && w < 200) begin tick(); w++; end
        check("done_mask", 32'(o_crc_done), 32'(exp_done));
        check("crc_result", 32'(o_crc_result), 32'(exp_crc));
        check("done_latency", 32'(cyc - t_end), 32'(ENG_LAT + 1));
`ifdef CRC_TIMEOUT_EN
        check("no_error_on_done", 32'(o_crc_error), 32'd0);
`endif
        tick();
        check("done_one_cycle", 32'(o_crc_done), 32'd0);
        check("idle_not_busy", 32'(o_busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(o_req_ready), 32'd0);
        check({tag, "_done"}, 32'(o_crc_done), 32'd0);
        check({tag, "_result"}, 32'(o_crc_result), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_data"}, 32'(o_crc_data), 32'd0);
        check({tag, "_ivalid"}, 32'(o_crc_input_valid), 32'd0);
        check({tag, "_enable"}, 32'(o_crc_enable), 32'd0);
        check({tag, "_endbyte"}, 32'(o_crc_end_byte), 32'd0);
    endtask

    typedef struct {
        int          who;
        int          n;
        logic [31:0] bytes;
        int          stall;
        logic        other;     // other requester also raises valid before this frame
        logic [1:0]  exp_done;
        logic [4:0]  exp_crc;
    } vec_t;

    vec_t       tbl[6];
    logic [4:0] last_crc;
    int         w;
    int         t_end;

    initial begin
        tbl[0] = '{0, 1, 32'h000000CB, 0,  1'b1, 2'b01, 5'h04};
        tbl[1] = '{1, 3, 32'h00C3B2A1, 0,  1'b1, 2'b10, crc5_frame(32'h00C3B2A1, 3)};
        tbl[2] = '{0, 2, 32'h00003412, 20, 1'b1, 2'b01, crc5_frame(32'h00003412, 2)};
        tbl[3] = '{1, 1, 32'h0000005A, 0,  1'b0, 2'b10, crc5_frame(32'h0000005A, 1)};
        tbl[4] = '{0, 1, 32'h000000FF, 0,  1'b0, 2'b01, crc5_frame(32'h000000FF, 1)};
        tbl[5] = '{1, 2, 32'h00008000, 0,  1'b0, 2'b10, crc5_frame(32'h00008000, 2)};

        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        eng_mute  = 1'b0;
        eng_spur  = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].other) req_valid[1 - tbl[i].who] = 1'b1;
            send_frame(tbl[i].who, tbl[i].n, tbl[i].bytes, tbl[i].stall,
                       tbl[i].exp_done, tbl[i].exp_crc);
            last_crc = tbl[i].exp_crc;
        end

        // Spurious engine valid while IDLE must be ignored.
        eng_spur = 1'b1;
        tick();
        eng_spur = 1'b0;
        check("spur_idle_busy", 32'(o_busy), 32'd0);
        check("spur_idle_result", 32'(o_crc_result), 32'(last_crc));

        // Non-last byte, then spurious valid in WAIT, then reset mid-WAIT.
        req_data[7:0] = 8'h55;
        req_last[0]   = 1'b0;
        req_valid[0]  = 1'b1;
        w = 0;
        while (o_req_ready == 2'b00 && w < 200) begin tick(); w++; end
        tick();
        req_valid[0] = 1'b0;
        tick();
        tick();
        eng_spur = 1'b1;
        tick();
        eng_spur = 1'b0;
        check("spur_wait_done", 32'(o_crc_done), 32'd0);
        check("spur_wait_endbyte", 32'(o_crc_end_byte), 32'd0);
        check("spur_wait_result", 32'(o_crc_result), 32'(last_crc));
        check("mid_wait_busy", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_frame(0, 1, 32'h0000003C, 0, 2'b01, crc5_frame(32'h0000003C, 1));
        last_crc = crc5_frame(32'h0000003C, 1);

`ifdef CRC_TIMEOUT_EN
        eng_mute      = 1'b1;
        req_data[7:0] = 8'h77;
        req_last[0]   = 1'b1;
        req_valid[0]  = 1'b1;
        w = 0;
        while (o_req_ready == 2'b00 && w < 200) begin tick(); w++; end
        tick();
        req_valid[0] = 1'b0;
        w = 0;
        while (!o_crc_end_byte && w < 200) begin tick(); w++; end
        t_end = cyc;
        w = 0;
        while (o_crc_done == 2'b00 && w < 200) begin tick(); w++; end
        check("tmo_latency", 32'(cyc - t_end), 32'(TC));
        check("tmo_error", 32'(o_crc_error), 32'd1);
        check("tmo_done", 32'(o_crc_done), 32'h1);
        check("tmo_result_hold", 32'(o_crc_result), 32'(last_crc));
        tick();
        check("tmo_error_pulse", 32'(o_crc_error), 32'd0);
        check("tmo_idle", 32'(o_busy), 32'd0);
        eng_mute = 1'b0;
`endif

        check("ready_never_both", 32'(both_ready), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
